// File: rtl/plru_array.sv
// Multi-set tree pseudo-LRU replacement array with optional per-way valid bits and flush sweep.
// Define PLRU_VALID_EN to enable valid storage, invalid-way-first fill allocation and inval.
module plru_array #(
    parameter int unsigned S_SET = 4,
    parameter int unsigned S_WAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_valid,
    input  logic [S_SET-1:0]   rd_set,
    output logic               victim_valid,
    output logic [S_WAY-1:0]   victim_way,
    input  logic               touch_valid,
    input  logic [S_SET-1:0]   touch_set,
    input  logic [S_WAY-1:0]   touch_way,
    input  logic               fill_valid,
    input  logic [S_SET-1:0]   fill_set,
    output logic [S_WAY-1:0]   fill_way,
    input  logic               inval_valid,
    input  logic [S_SET-1:0]   inval_set,
    input  logic [S_WAY-1:0]   inval_way,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done
);

    localparam int unsigned NUM_SETS = 1 << S_SET;
    localparam int unsigned NUM_WAYS = 1 << S_WAY;
    localparam int unsigned TREE_W   = NUM_WAYS - 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    // Follow the stored direction bits from the root; way[d] is the decision at depth d.
    function automatic logic [S_WAY-1:0] tree_victim(input logic [TREE_W-1:0] t);
        logic [S_WAY-1:0] node;
        logic [S_WAY-1:0] way;
        node = '0;
        way  = '0;
        for (int unsigned d = 0; d < S_WAY; d++) begin
            for (int unsigned n = 0; n < TREE_W; n++) begin
                if (node == S_WAY'(n)) way[d] = t[n];
            end
            node = S_WAY'(2 * node + 1 + way[d]);
        end
        return way;
    endfunction

    // Point every node on the path to w away from it, making w most recently used.
    function automatic logic [TREE_W-1:0] tree_update(input logic [TREE_W-1:0] t,
                                                      input logic [S_WAY-1:0] w);
        logic [TREE_W-1:0] r;
        logic [S_WAY-1:0]  node;
        r    = t;
        node = '0;
        for (int unsigned d = 0; d < S_WAY; d++) begin
            for (int unsigned n = 0; n < TREE_W; n++) begin
                if (node == S_WAY'(n)) r[n] = ~w[d];
            end
            node = S_WAY'(2 * node + 1 + w[d]);
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [S_SET-1:0]   cnt_q, cnt_d;
    logic               busy_d, done_d;

    logic [TREE_W-1:0]  tree_q [NUM_SETS];
`ifdef PLRU_VALID_EN
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic                inval_go;
`else
    logic                unused_inval;
    assign unused_inval = ^{inval_valid, inval_set, inval_way};
`endif

    logic               accept;
    logic               fill_go;
    logic               touch_go;
    logic               tree_we;
    logic [S_SET-1:0]   wr_set;
    logic [S_WAY-1:0]   wr_way;
    logic [TREE_W-1:0]  tree_new;
    logic [TREE_W-1:0]  rd_tree;

    // Flush sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == S_SET'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FLUSH);
        done_d = (state_d == FLUSH) && (cnt_d == S_SET'(NUM_SETS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            flush_done <= done_d;
        end
    end

    // Fill allocation: lowest invalid way if any, else the PLRU victim.
    always_comb begin
`ifdef PLRU_VALID_EN
        logic [NUM_WAYS-1:0] fill_valids;
        fill_valids = valid_q[fill_set];
`endif
        fill_way = tree_victim(tree_q[fill_set]);
`ifdef PLRU_VALID_EN
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!fill_valids[w]) fill_way = S_WAY'(w);
        end
`endif
    end

    // Single write per cycle, fill > inval > touch, with read bypass of the tree write.
    always_comb begin
        accept  = (state_q == IDLE);
        fill_go = accept & fill_valid;
`ifdef PLRU_VALID_EN
        inval_go = accept & inval_valid & ~fill_valid;
        touch_go = accept & touch_valid & ~fill_valid & ~inval_valid;
`else
        touch_go = accept & touch_valid & ~fill_valid;
`endif
        tree_we  = fill_go | touch_go;
        wr_set   = fill_go ? fill_set : touch_set;
        wr_way   = fill_go ? fill_way : touch_way;
        tree_new = tree_update(tree_q[wr_set], wr_way);
        rd_tree  = (tree_we && (wr_set == rd_set)) ? tree_new : tree_q[rd_set];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            victim_valid <= accept & rd_valid;
            if (accept && rd_valid) victim_way <= tree_victim(rd_tree);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= '0;
`ifdef PLRU_VALID_EN
                valid_q[s] <= '0;
`endif
            end
        end else if (state_q == FLUSH) begin
            tree_q[cnt_q] <= '0;
`ifdef PLRU_VALID_EN
            valid_q[cnt_q] <= '0;
`endif
        end else begin
            if (tree_we) tree_q[wr_set] <= tree_new;
`ifdef PLRU_VALID_EN
            if (fill_go)  valid_q[fill_set][fill_way]   <= 1'b1;
            if (inval_go) valid_q[inval_set][inval_way] <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_plru_array.sv
// Randomized self-checking bench for plru_array against a per-set tree/valid reference model.
module tb_plru_array;

    localparam int SS = 2;
    localparam int SW = 2;
    localparam int NS = 1 << SS;
    localparam int NW = 1 << SW;
    localparam int TW = NW - 1;

    logic          clk;
    logic          rst;
    logic          rd_valid;
    logic [SS-1:0] rd_set;
    logic          victim_valid;
    logic [SW-1:0] victim_way;
    logic          touch_valid;
    logic [SS-1:0] touch_set;
    logic [SW-1:0] touch_way;
    logic          fill_valid;
    logic [SS-1:0] fill_set;
    logic [SW-1:0] fill_way;
    logic          inval_valid;
    logic [SS-1:0] inval_set;
    logic [SW-1:0] inval_way;
    logic          flush_req;
    logic          busy;
    logic          flush_done;

    plru_array #(.S_SET(SS), .S_WAY(SW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_set(rd_set),
        .victim_valid(victim_valid), .victim_way(victim_way),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: node bits per set, valid flags per way, flush progress.
    int m_tree  [NS][TW];
    int m_valid [NS][NW];
    int m_busy, m_cnt, m_vv, m_vw;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int m_victim(input int s);
        int node = 0;
        int v = 0;
        for (int d = 0; d < SW; d++) begin
            int b = m_tree[s][node];
            v    = v + (b << d);
            node = 2 * node + 1 + b;
        end
        return v;
    endfunction

    task automatic m_touch(input int s, input int w);
        int node = 0;
        for (int d = 0; d < SW; d++) begin
            int b = (w >> d) & 1;
            m_tree[s][node] = 1 - b;
            node = 2 * node + 1 + b;
        end
    endtask

    function automatic int m_fill_way(input int s);
`ifdef PLRU_VALID_EN
        for (int w = 0; w < NW; w++) if (m_valid[s][w] == 0) return w;
`endif
        return m_victim(s);
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NS; s++) begin
            for (int n = 0; n < TW; n++) m_tree[s][n] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
        end
        m_busy = 0; m_cnt = 0; m_vv = 0; m_vw = 0;
    endtask

    // One clock cycle: drive, check fill_way, step the model, then check registered outputs.
    task automatic cycle(input int r, input int rv, input int rs, input int tv, input int ts,
                         input int tw, input int fv, input int fs, input int iv, input int ivs,
                         input int iw, input int fq);
        int fw;
        rst = 1'(r); rd_valid = 1'(rv); rd_set = SS'(rs);
        touch_valid = 1'(tv); touch_set = SS'(ts); touch_way = SW'(tw);
        fill_valid = 1'(fv); fill_set = SS'(fs);
        inval_valid = 1'(iv); inval_set = SS'(ivs); inval_way = SW'(iw);
        flush_req = 1'(fq);
        #1;
        if (r == 0 && m_busy == 0 && fv != 0) check("fill_way", int'(fill_way), m_fill_way(fs));
        if (r != 0) begin
            m_reset();
        end else if (m_busy != 0) begin
            for (int n = 0; n < TW; n++) m_tree[m_cnt][n] = 0;
            for (int w = 0; w < NW; w++) m_valid[m_cnt][w] = 0;
            m_vv = 0;
            if (m_cnt == NS - 1) begin m_busy = 0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (fv != 0) begin
                fw = m_fill_way(fs);
                m_touch(fs, fw);
                m_valid[fs][fw] = 1;
            end
`ifdef PLRU_VALID_EN
            else if (iv != 0) m_valid[ivs][iw] = 0;
`endif
            else if (tv != 0) m_touch(ts, tw);
            m_vv = rv;
            if (rv != 0) m_vw = m_victim(rs);
            if (fq != 0) begin m_busy = 1; m_cnt = 0; end
        end
        @(posedge clk);
        #1;
        check("victim_valid", int'(victim_valid), m_vv);
        if (m_vv != 0) check("victim_way", int'(victim_way), m_vw);
        check("busy", int'(busy), m_busy);
        check("flush_done", int'(flush_done), (m_busy != 0 && m_cnt == NS - 1) ? 1 : 0);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int s);
        cycle(0, 1, s, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input int s);
        cycle(0, 0, 0, 0, 0, 0, 1, s, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        rst = 1'b1; rd_valid = 1'b0; rd_set = '0;
        touch_valid = 1'b0; touch_set = '0; touch_way = '0;
        fill_valid = 1'b0; fill_set = '0;
        inval_valid = 1'b0; inval_set = '0; inval_way = '0;
        flush_req = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        check("reset_victim_way", int'(victim_way), 0);
        rd(1);
        check("first_victim", int'(victim_way), 0);

        // Fill and touch on set 1
        repeat (4) fill(1);
        rd(1);
        cycle(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        rd(1);
        check("victim_after_touch", int'(victim_way), 1);

        // Bypass of a same-cycle touch
        do_reset();
        cycle(0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        check("bypass_victim", int'(victim_way), 1);

        // Fill beats a same-cycle touch
        do_reset();
        cycle(0, 0, 0, 1, 3, 1, 1, 3, 0, 0, 0, 0);
        rd(3);
        check("priority_victim", int'(victim_way), 1);

        // Invalidate then refill on a full set
        do_reset();
        repeat (4) fill(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
        fill(1);

        // Full flush sweep with a read while busy
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        rd(1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        idle();
        for (int s = 0; s < NS; s++) fill(s);

        // Reset part-way through a sweep
        fill(0); fill(2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        do_reset();
        for (int s = 0; s < NS; s++) rd(s);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, NW - 1)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, NS - 1)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, NW - 1)),
                  ($urandom_range(0, 39) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plru_array.md
# plru_array

Multi-set tree pseudo-LRU replacement array for the branch-target buffer and other set-associative structures in the mp4 core. It holds one (2^S_WAY − 1)-bit PLRU tree per set, plus per-way valid bits. It provides:
- a registered victim lookup with same-cycle write bypass,
- a fill allocator that prefers invalid ways,
- hit touches and single-way invalidation,
- a multi-cycle flush sweep driven by a small state machine.

## Interface
Parameters:
- S_SET, 4, log2 number of sets (NUM_SETS = 2^S_SET)
- S_WAY, 2, log2 number of ways (NUM_WAYS = 2^S_WAY, tree bits = NUM_WAYS−1), S_WAY ≥ 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_valid  in  1  victim lookup request
- rd_set  in  S_SET  set to look up
- victim_valid  out  1  victim_way valid, one cycle after an accepted rd_valid
- victim_way  out  S_WAY  PLRU victim of rd_set
- touch_valid  in  1  hit update: make touch_way MRU in touch_set
- touch_set  in  S_SET
- touch_way  in  S_WAY
- fill_valid  in  1  allocate a way in fill_set
- fill_set  in  S_SET
- fill_way  out  S_WAY  allocated way, combinational, same cycle as fill_valid
- inval_valid  in  1  clear the valid bit of inval_way in inval_set
- inval_set  in  S_SET
- inval_way  in  S_WAY
- flush_req  in  1  start a flush sweep (pulse)
- busy  out  1  flush in progress; all requests ignored
- flush_done  out  1  one-cycle pulse in the final sweep cycle

## Operation

**Tree encoding**
- Node 0 is the root. Node p has children 2p+1 (bit 0) and 2p+2 (bit 1).
- Way index bit way[d] is the direction taken at depth d, so the LSB is the root decision.

**Victim walk**
- Start at the root and follow the stored bits. way[d] = the node bit at depth d.

**Update (touch or fill)**
- On every node along the path to the target way, write the opposite of the direction taken.

**Fill allocation**
- If any way in fill_set is invalid, allocate the lowest-index invalid way.
- Otherwise allocate the PLRU victim.
- The allocated way is marked valid and made MRU.

**Inval**
- Clears the valid bit of inval_way only. The tree is unchanged.

**Write priority, one write per cycle**
- Order: fill > inval > touch. Lower-priority requests in the same cycle are dropped, whatever their set.

**State machine**
- IDLE → FLUSH on flush_req.
- In FLUSH, counter cnt clears the tree and valid bits of set cnt each cycle, counting 0 … NUM_SETS−1.
- When cnt == NUM_SETS−1: assert flush_done, then go to IDLE with cnt = 0.
- busy = (state == FLUSH).
- While busy, rd/fill/touch/inval/flush_req are ignored: no state change and victim_valid stays 0. fill_way is don't-care while busy.

**Reset**
- All trees = 0, all valid = 0, state IDLE, cnt = 0.
- Outputs after reset: victim_valid = 0, victim_way = 0, busy = 0, flush_done = 0.
- Reset during FLUSH aborts the sweep immediately, and flush_done is not pulsed.

## Timing
- Lookup latency is 1 cycle: victim_valid and victim_way are registered.
- Bypass: if an accepted write (fill or touch) targets rd_set in the same cycle, victim_way reflects the post-update tree.
- fill_way is combinational from current state, with no bypass of other same-cycle requests (none apply, since fill wins).
- Array writes take effect at the next posedge.
- Flush timing: flush_req at cycle 0 → busy in cycles 1 … NUM_SETS; flush_done in cycle NUM_SETS; requests are accepted again from cycle NUM_SETS+1.
- flush_req while busy has no effect. The sweep is not restarted.

## Configuration
- Macro: PLRU_VALID_EN.
- Defined: valid bits exist, fill prefers invalid ways, and inval is functional.
- Undefined: no valid storage. Fill always takes the PLRU victim. inval_valid is ignored. Flush clears trees only.

## Test plan
All scenarios use S_SET=2, S_WAY=2.
- **Reset and lookup:** after rst, rd set 1 → next cycle victim_valid=1, victim_way=0.
- **Fill and touch on set 1:**
  - Fill four times → fill_way 0, 1, 2, 3.
  - rd → victim 0.
  - Touch way 0, then rd → victim 1.
- **Bypass:** from reset, touch set 2 way 0 and rd set 2 in the same cycle → victim_way=1 next cycle.
- **Priority:** fill and touch on set 3 in the same cycle from reset → fill_way=0; a later rd returns victim 1, showing the touch was dropped.
- **Invalidation and flush:**
  - After set 1 is full, inval way 2; next fill → fill_way=2 with PLRU_VALID_EN, fill_way=0 without.
  - flush_req at cycle 0 → busy in cycles 1–4, flush_done in cycle 4; a rd issued in cycle 2 gets no response; afterwards all fills return way 0.
- **Reset mid-flush:** rst in cycle 2 of a sweep → busy=0 next cycle, no flush_done, all sets read victim 0.
